// File: rtl/sar_scan_controller_if.sv
// Signal bundle between the SAR scan controller (master) and the analog front end / result consumer (slave).
interface sar_scan_controller_if #(
  parameter int N = 8,
  parameter int C = 4
);
  localparam int CW = $clog2(C);

  // go is a level sampled at a clock edge and only accepted while idle; valid and done
  // are single-cycle pulses with no backpressure, result/result_ch hold until the next valid.
  logic          go;
  logic          scan;
  logic [CW-1:0] ch_sel;
  logic          abort;
  logic          cmp;
  logic          busy;
  logic          sample;
  logic [CW-1:0] ch;
  logic [N-1:0]  value;
  logic          valid;
  logic [N-1:0]  result;
  logic [CW-1:0] result_ch;
  logic          done;
  logic [1:0]    state;

  modport master (
    input  go, scan, ch_sel, abort, cmp,
    output busy, sample, ch, value, valid, result, result_ch, done, state
  );

  modport slave (
    output go, scan, ch_sel, abort, cmp,
    input  busy, sample, ch, value, valid, result, result_ch, done, state
  );
endinterface

// File: rtl/sar_scan_controller.sv
// Multi-channel SAR ADC controller: sample phase, N-step binary search on cmp,
// single-channel or full-scan operation with abort.
module sar_scan_controller #(
  parameter int N = 8,
  parameter int S = 3,
  parameter int C = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  sar_scan_controller_if.master  bus
);
  localparam int CW = $clog2(C);
  localparam int KW = $clog2(N);
  localparam logic [N-1:0]  MSB     = {1'b1, {(N-1){1'b0}}};
  localparam logic [3:0]    S_LAST  = 4'(S);
  localparam logic [3:0]    K_TOP   = 4'(N-1);
  localparam logic [CW-1:0] CH_LAST = CW'(C-1);

  typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, CONVERT = 2'd2} state_t;

  state_t        state;
  logic          scan_mode;
  logic [3:0]    cnt;
  logic          busy;
  logic          sample;
  logic [CW-1:0] ch;
  logic [N-1:0]  value;
  logic          valid;
  logic [N-1:0]  result;
  logic [CW-1:0] result_ch;
  logic          done;

  logic [KW-1:0] k;
  logic [N-1:0]  trial;
  logic [CW-1:0] clamped;
  logic [CW-1:0] ch_start;

  assign k = cnt[KW-1:0];

  // Resolve the current bit from cmp and tentatively set the next lower one.
  always_comb begin
    trial    = value;
    trial[k] = bus.cmp;
    if (k != '0) trial[k - KW'(1)] = 1'b1;
  end

  // A power-of-two channel count cannot be out of range, so no clamp is built.
  if ((1 << CW) == C) begin : g_pow2
    assign clamped = bus.ch_sel;
  end else begin : g_clamp
    assign clamped = (bus.ch_sel > CH_LAST) ? CH_LAST : bus.ch_sel;
  end

  assign ch_start = bus.scan ? '0 : clamped;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      scan_mode <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      sample    <= 1'b0;
      ch        <= '0;
      value     <= MSB;
      valid     <= 1'b0;
      result    <= '0;
      result_ch <= '0;
      done      <= 1'b0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go && !bus.abort) begin
            state     <= SAMPLE;
            scan_mode <= bus.scan;
            ch        <= ch_start;
            busy      <= 1'b1;
            sample    <= 1'b1;
            value     <= MSB;
            cnt       <= 4'd1;
          end
        end
        SAMPLE: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            sample <= 1'b0;
            value  <= MSB;
            cnt    <= '0;
          end else if (cnt == S_LAST) begin
            state  <= CONVERT;
            sample <= 1'b0;
            cnt    <= K_TOP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        CONVERT: begin
          if (bus.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            value <= MSB;
            cnt   <= '0;
          end else if (cnt == 4'd0) begin
            result    <= trial;
            result_ch <= ch;
            valid     <= 1'b1;
            if (scan_mode && ch < CH_LAST) begin
              state  <= SAMPLE;
              ch     <= ch + CW'(1);
              sample <= 1'b1;
              value  <= MSB;
              cnt    <= 4'd1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              value <= trial;
            end
          end else begin
            value <= trial;
            cnt   <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.sample    = sample;
  assign bus.ch        = ch;
  assign bus.value     = value;
  assign bus.valid     = valid;
  assign bus.result    = result;
  assign bus.result_ch = result_ch;
  assign bus.done      = done;
  assign bus.state     = state;
endmodule

// File: tb/tb_sar_scan_controller.sv
// Directed bench for sar_scan_controller: single, scan, go/abort corners, reset, small parameters.
module tb_sar_scan_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_c;

  sar_scan_controller_if #(.N(8), .C(4)) ifa();
  sar_scan_controller_if #(.N(2), .C(2)) ifb();
  sar_scan_controller_if #(.N(2), .C(3)) ifc();

  sar_scan_controller #(.N(8), .S(3), .C(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.master));
  sar_scan_controller #(.N(2), .S(1), .C(2)) dut_b (.clk(clk), .rst(rst_c), .bus(ifb.master));
  sar_scan_controller #(.N(2), .S(1), .C(3)) dut_c (.clk(clk), .rst(rst_c), .bus(ifc.master));

  // Analog input per channel, expressed as the ideal code; comparator is code >= DAC level.
  logic [7:0] code_a [4];
  logic [1:0] code_b [2];
  logic [1:0] code_c [4];
  assign ifa.cmp = (code_a[ifa.ch] >= ifa.value);
  assign ifb.cmp = (code_b[ifb.ch] >= ifb.value);
  assign ifc.cmp = (code_c[ifc.ch] >= ifc.value);

  int checks;
  int errors;
  int stray_done;
  logic [7:0] exp_q[$];
  logic [7:0] val_seq [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the selected DUT pulses valid; n counts the edges advanced.
  task automatic wait_valid(input int which, output int n);
    logic v;
    logic d;
    n = 0;
    do begin
      tick();
      n++;
      v = (which == 0) ? ifa.valid : (which == 1) ? ifb.valid : ifc.valid;
      d = (which == 0) ? ifa.done  : (which == 1) ? ifb.done  : ifc.done;
      if (d && !v) stray_done++;
    end while (!v && n < 200);
    if (!v) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int lat;
    logic [7:0] e;
    checks = 0;
    errors = 0;
    stray_done = 0;
    val_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    code_a = '{8'h00, 8'hFF, 8'hA5, 8'h00};
    code_b = '{2'b10, 2'b01};
    code_c = '{2'b00, 2'b00, 2'b11, 2'b00};
    ifa.go = 0; ifa.scan = 0; ifa.ch_sel = '0; ifa.abort = 0;
    ifb.go = 0; ifb.scan = 0; ifb.ch_sel = '0; ifb.abort = 0;
    ifc.go = 0; ifc.scan = 0; ifc.ch_sel = '0; ifc.abort = 0;
    rst_a = 0;
    rst_c = 0;
    tick();
    tick();

    // Reset values
    check("rst_busy", ifa.busy, 0);
    check("rst_sample", ifa.sample, 0);
    check("rst_ch", ifa.ch, 0);
    check("rst_value", ifa.value, 8'h80);
    check("rst_valid", ifa.valid, 0);
    check("rst_result", ifa.result, 0);
    check("rst_result_ch", ifa.result_ch, 0);
    check("rst_done", ifa.done, 0);
    check("rst_value_n2", ifb.value, 2'b10);
    rst_a = 1;
    rst_c = 1;
    tick();

    // Single conversion of 0xA5 on channel 2
    ifa.ch_sel = 2; ifa.go = 1;
    tick(); lat = 1;
    ifa.go = 0;
    check("single_sample", ifa.sample, 1);
    check("single_busy", ifa.busy, 1);
    check("single_ch", ifa.ch, 2);
    tick(); tick(); tick(); lat += 3;
    check("single_conv_sample", ifa.sample, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("value_seq%0d", i), ifa.value, val_seq[i]);
      check("single_no_valid", ifa.valid, 0);
      if (i < 7) begin tick(); lat++; end
    end
    wait_valid(0, n);
    check("single_latency", lat + n, 12);
    check("single_result", ifa.result, 8'hA5);
    check("single_result_ch", ifa.result_ch, 2);
    check("single_done", ifa.done, 1);
    check("single_busy_end", ifa.busy, 0);
    check("single_value_hold", ifa.value, 8'hA5);
    tick();
    check("single_valid_pulse", ifa.valid, 0);
    check("single_done_pulse", ifa.done, 0);
    check("single_result_hold", ifa.result, 8'hA5);

    // go during CONVERT ignored; go in done cycle accepted
    ifa.ch_sel = 1; ifa.go = 1;
    tick(); lat = 1;
    ifa.go = 0;
    tick(); tick(); tick(); tick(); lat += 4;
    ifa.go = 1; ifa.ch_sel = 3; ifa.scan = 1;
    tick(); lat++;
    ifa.go = 0; ifa.scan = 0;
    wait_valid(0, n);
    check("ignore_go_latency", lat + n, 12);
    check("ignore_go_result", ifa.result, 8'hFF);
    check("ignore_go_result_ch", ifa.result_ch, 1);
    check("ignore_go_done", ifa.done, 1);
    ifa.go = 1; ifa.ch_sel = 0;
    tick();
    ifa.go = 0;
    check("go_in_done_sample", ifa.sample, 1);
    check("go_in_done_ch", ifa.ch, 0);

    // abort in the third CONVERT cycle
    for (int i = 0; i < 5; i++) tick();
    check("pre_abort_busy", ifa.busy, 1);
    ifa.abort = 1;
    tick();
    ifa.abort = 0;
    check("abort_busy", ifa.busy, 0);
    check("abort_sample", ifa.sample, 0);
    check("abort_value", ifa.value, 8'h80);
    check("abort_state", ifa.state, 0);
    check("abort_result", ifa.result, 8'hFF);
    check("abort_result_ch", ifa.result_ch, 1);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_valid", ifa.valid, 0);
      check("abort_no_done", ifa.done, 0);
      tick();
    end
    ifa.abort = 1; ifa.go = 1;
    tick();
    ifa.abort = 0; ifa.go = 0;
    check("abort_go_idle", ifa.busy, 0);

    // Full scan of four channels
    code_a = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    for (int i = 0; i < 4; i++) exp_q.push_back(code_a[i]);
    stray_done = 0;
    ifa.scan = 1; ifa.go = 1;
    tick();
    ifa.go = 0; ifa.scan = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(0, n);
      check($sformatf("scan_period%0d", k), (k == 0) ? n + 1 : n, (k == 0) ? 12 : 11);
      e = exp_q.pop_front();
      check($sformatf("scan_result%0d", k), ifa.result, e);
      check($sformatf("scan_result_ch%0d", k), ifa.result_ch, k);
      check($sformatf("scan_done%0d", k), ifa.done, (k == 3) ? 1 : 0);
      check($sformatf("scan_ch%0d", k), ifa.ch, (k < 3) ? k + 1 : 3);
      check($sformatf("scan_busy%0d", k), ifa.busy, (k < 3) ? 1 : 0);
      if (k < 3) check($sformatf("scan_next_sample%0d", k), ifa.sample, 1);
    end
    check("scan_stray_done", stray_done, 0);

    // Reset mid-scan, with go asserted during reset
    ifa.scan = 1; ifa.go = 1;
    tick();
    ifa.go = 0; ifa.scan = 0;
    wait_valid(0, n);
    wait_valid(0, n);
    tick(); tick(); tick();
    check("pre_rst_result", ifa.result, 8'hFF);
    rst_a = 0; ifa.go = 1;
    tick();
    check("mid_rst_busy", ifa.busy, 0);
    check("mid_rst_sample", ifa.sample, 0);
    check("mid_rst_ch", ifa.ch, 0);
    check("mid_rst_value", ifa.value, 8'h80);
    check("mid_rst_valid", ifa.valid, 0);
    check("mid_rst_result", ifa.result, 0);
    check("mid_rst_result_ch", ifa.result_ch, 0);
    check("mid_rst_done", ifa.done, 0);
    rst_a = 1; ifa.go = 0;
    tick();
    check("post_rst_idle", ifa.busy, 0);
    check("post_rst_valid", ifa.valid, 0);

    // Corner parameters: N=2 S=1 latency, and channel clamp with C=3
    ifb.ch_sel = 1; ifb.go = 1;
    ifc.ch_sel = 3; ifc.go = 1;
    tick();
    ifb.go = 0; ifc.go = 0;
    check("clamp_ch", ifc.ch, 2);
    check("n2_sample", ifb.sample, 1);
    wait_valid(1, n);
    check("n2_latency", n + 1, 4);
    check("n2_result", ifb.result, 2'b01);
    check("n2_result_ch", ifb.result_ch, 1);
    check("n2_done", ifb.done, 1);
    check("clamp_valid", ifc.valid, 1);
    check("clamp_result", ifc.result, 2'b11);
    check("clamp_result_ch", ifc.result_ch, 2);

    ifb.scan = 1; ifb.go = 1;
    tick();
    ifb.go = 0; ifb.scan = 0;
    wait_valid(1, n);
    check("n2_scan_lat0", n + 1, 4);
    check("n2_scan_result0", ifb.result, 2'b10);
    check("n2_scan_done0", ifb.done, 0);
    wait_valid(1, n);
    check("n2_scan_period", n, 3);
    check("n2_scan_result1", ifb.result, 2'b01);
    check("n2_scan_ch1", ifb.result_ch, 1);
    check("n2_scan_done1", ifb.done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sar_scan_controller.md
# sar_scan_controller

Parametrised multi-channel SAR ADC controller. Drives the sample switch, the analog input mux select and the N-bit trial code to the capacitive DAC. It runs the binary search on the comparator output and delivers one result per converted channel, tagged with its channel number. It supports single-channel conversion and automatic scan of all channels, plus abort, and sits between the analog front end (mux, S/H, DAC, comparator) and the digital result consumer.

## Interface
- N, 8, conversion resolution in bits (2..16)
- S, 3, sample phase length in clock cycles (1..15)
- C, 4, number of input channels (2..16); CW = $clog2(C)
- clk  input  1  global clock, all logic on rising edge
- rst  input  1  reset; synchronous and active-low
- go  input  1  start request, accepted only in IDLE
- scan  input  1  mode at go: 0 = single channel ch_sel, 1 = scan channels 0..C-1
- ch_sel  input  CW  channel for single mode, captured at go; values >= C are treated as C-1
- abort  input  1  terminate the current operation
- cmp  input  1  comparator output: 1 = input >= DAC trial level
- busy  output  1  high in SAMPLE and CONVERT
- sample  output  1  sample switch enable
- ch  output  CW  analog mux select
- value  output  N  DAC trial code
- valid  output  1  one-cycle pulse: result/result_ch are new
- result  output  N  last completed conversion code
- result_ch  output  CW  channel of result
- done  output  1  one-cycle pulse: single conversion or full scan finished

## Operation
- States: IDLE, SAMPLE, CONVERT. All outputs are registered.
- Reset (rst=0 at a clock edge) has top priority:
  - state IDLE, busy 0, sample 0, ch 0
  - value = MSB only (1000..0), valid 0, result 0, result_ch 0, done 0
  - internal counters 0
- IDLE + go=1:
  - ch = (scan ? 0 : clamp(ch_sel)), mode latched.
  - Go to SAMPLE with sample=1, value = MSB only, counter = 1.
- go is ignored outside IDLE; scan and ch_sel are ignored except at accepted go.
- SAMPLE: sample=1 for exactly S cycles, then CONVERT with sample=0 and bit index k = N-1.
- CONVERT cycle for bit k, on the clock edge:
  - value[k] <= cmp
  - value[k-1] <= 1 if k > 0
  - other bits hold; then k decrements.
- Last bit (k = 0) edge:
  - result <= final code {value[N-1:1], cmp}, result_ch <= ch, valid <= 1.
  - value holds the final code.
  - If scan mode and ch < C-1: ch <= ch+1, enter SAMPLE (value reset to MSB only).
  - Otherwise: enter IDLE, done <= 1, ch holds.
- abort=1 in SAMPLE or CONVERT (priority over all but reset):
  - Next state IDLE, sample 0, busy 0, value = MSB only.
  - No valid, no done; result and result_ch keep their previous values.
  - abort in IDLE has no effect.
- abort and go in the same IDLE cycle: go is ignored.
- valid and done are high for one cycle only; result and result_ch hold until the next valid.

## Timing
- go sampled high at edge t (IDLE):
  - sample=1 in cycles t+1..t+S
  - CONVERT in cycles t+S+1..t+S+N, with cmp sampled at the end of each
  - valid (and done in single mode) high in cycle t+S+N+1
- Per-channel latency is S+N+1 cycles from the go edge to valid.
- Scan mode:
  - Next channel's sample=1 starts in the same cycle as the previous channel's valid.
  - Channel period is S+N cycles.
  - Full scan: valid pulses at t+k(S+N)+S+N+1 for k = 0..C-1; done coincides with the last valid.
  - busy falls in that same last cycle.
- cmp must be stable for setup before each CONVERT edge; the DAC settles for one cycle on each value change.
- A new go is accepted in the cycle done is high (state already IDLE).

## Test plan
- Single conversion, N=8, S=3, ch_sel=2, comparator model with analog code 0xA5:
  - Expect valid at go+12, result=0xA5, result_ch=2, done coincident.
  - value sequence 80,C0,A0,B0,A8,A4,A6,A5.
- Scan, C=4, channel codes 0x00/0xFF/0x5A/0x81:
  - Expect four valid pulses 11 cycles apart with matching result/result_ch 0..3.
  - done only with the 4th pulse; ch sequence 0,1,2,3.
- go pulsed during CONVERT and in the final done cycle:
  - First go is ignored.
  - Second go starts a new conversion, with sample=1 on the next cycle.
- abort in the 3rd CONVERT cycle:
  - IDLE next cycle, no valid/done, result unchanged from the prior conversion.
  - value=0x80.
- rst=0 held for 1 cycle mid-scan:
  - All outputs equal reset values at the next edge.
  - No valid; go is ignored while rst=0.
- Corner parameters N=2, S=1, C=2, and ch_sel=3 with C=3:
  - Latency 4 cycles.
  - Clamp gives ch=2, result_ch=2.
